median_feeder: RTL and testbench
================================

Name: median_feeder

Overview:
- Initiator side of the serial median protocol (DI/DSI in, DO/DSO out).
- Accepts one 3x3 pixel window in parallel through a valid/ready handshake and serialises it onto DI with DSI high for exactly 9 cycles.
- Waits for DSO, captures DO, and presents the median through an output valid/ready handshake.
- Sits between the window-extraction logic and the median core.

Parameters:
- SIZE, 8, pixel width in bits.
- TIMEOUT, 63, maximum cycles in WAIT before an error is flagged (only with the optional feature).

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; asynchronous, active-high.
- WIN  in  9*SIZE  window; pixel k at bits [k*SIZE +: SIZE]; pixel 0 is sent first.
- WIN_VALID  in  1  window offered.
- WIN_READY  out  1  window accepted when WIN_VALID and WIN_READY are both high.
- MED_DI  out  SIZE  pixel to the median core.
- MED_DSI  out  1  pixel strobe to the median core.
- MED_DO  in  SIZE  median from the core.
- MED_DSO  in  1  median valid from the core.
- RES  out  SIZE  captured median.
- RES_VALID  out  1  result available.
- RES_READY  in  1  result consumed when RES_VALID and RES_READY are both high.
- ERR  out  1  timeout flag (optional feature).

Behaviour:
- Reset (async, RST=1): state IDLE; MED_DSI=0, MED_DI=0, RES=0, RES_VALID=0, ERR=0, pixel index 0, wait counter 0. WIN_READY=0 while RST is high.
- All outputs are registered except WIN_READY, which is combinational: high iff state==IDLE.
- State IDLE:
  - On the handshake edge, latch WIN into a 9-entry shift register.
  - Set MED_DSI<=1 and MED_DI<=pixel 0; go to SEND.
  - MED_DSI is therefore high in cycles 1..9 after the handshake cycle, carrying pixels 0..8 in order.
- State SEND:
  - 4-bit index advances by one per cycle.
  - After pixel 8 has been driven for one cycle: MED_DSI<=0, MED_DI<=0, clear the wait counter, go to WAIT.
  - MED_DSI is never deasserted mid-window.
- State WAIT:
  - MED_DSO is sampled only in this state. A stale DSO high during SEND is ignored, because the core clears its counter while DSI is high.
  - Wait counter increments each cycle.
  - First cycle with MED_DSO=1: RES<=MED_DO, RES_VALID<=1, go to HOLD.
  - With the nominal core, MED_DSO arrives 41 cycles after MED_DSI falls.
- State HOLD:
  - RES and RES_VALID are held stable until RES_READY=1.
  - On that edge: RES_VALID<=0, go to IDLE. The next window can be accepted one cycle later; there is no overlap.
  - RES_READY may be high before RES_VALID; the transfer completes on the first cycle both are high.
- RES_READY is ignored outside HOLD. WIN_VALID is ignored outside IDLE; WIN may change freely after acceptance.
- Wait counter width is $clog2(TIMEOUT+1) bits and saturates; it never wraps.
- RST asserted mid-window: MED_DSI drops immediately and the partial window is discarded. The core restarts cleanly on the next full 9-pixel burst.

Optional Feature:
- MEDIAN_FEEDER_TIMEOUT_EN defined:
  - If the wait counter reaches TIMEOUT in WAIT without MED_DSO, set ERR<=1 and RES<=0, and go to IDLE with RES_VALID kept 0.
  - ERR is sticky until RST.
  - A DSO in the same cycle as the timeout wins; no error is raised.
- Undefined: no timeout logic; WAIT is held indefinitely; ERR is tied to 0.

Decomposition:
- Shared package median_pkg:
  - state enum {IDLE, SEND, WAIT, HOLD};
  - localparam NB_PIX=9;
  - localparam MED_LATENCY=41.
- One natural sub-module: median_shreg, the 9-entry SIZE-bit parallel-load/serial-out shift register with load and shift enables.
- The FSM and handshakes stay in median_feeder.

Test Plan:
- Reset mid-SEND: assert RST during the 5th DSI cycle -> MED_DSI=0 asynchronously, all outputs at reset values, WIN_READY=1 one cycle after RST drops.
- Window {9,1,8,2,7,3,6,4,5} with the real median core attached -> MED_DI sequence 9,1,8,2,7,3,6,4,5 over 9 DSI-high cycles; RES=5 with RES_VALID rising 42 cycles after MED_DSI falls.
- Backpressure: RES_READY=0 for 10 cycles, then 1 -> RES stable at 5 throughout; WIN_READY=0 until the cycle after the transfer.
- Back-to-back windows {0..8} then {255 x9}, with WIN_VALID held high and RES_READY=1 -> RES=4, then RES=255; exactly 9 DSI-high cycles per window; DSO during SEND ignored.
- Stale DSO: core model holds MED_DSO=1 throughout SEND, then drops it -> no capture before WAIT.
- With MEDIAN_FEEDER_TIMEOUT_EN and TIMEOUT=63, core model never asserts DSO -> ERR=1 after 63 WAIT cycles, RES_VALID stays 0, WIN_READY=1 next cycle.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types and constants for the median feeder and its shift register.
package median_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;
  localparam int NB_PIX      = 9;
  localparam int MED_LATENCY = 41;
endpackage

// File: rtl/median_feeder_if.sv
// Window-in, serial median link and result-out signals of the median feeder.
interface median_feeder_if
  import median_pkg::*;
#(
  parameter int SIZE = 8
);
  logic [NB_PIX*SIZE-1:0] win;
  logic                   win_valid;
  logic                   win_ready;
  logic [SIZE-1:0]        med_di;
  logic                   med_dsi;
  logic [SIZE-1:0]        med_do;
  logic                   med_dso;
  logic [SIZE-1:0]        res;
  logic                   res_valid;
  logic                   res_ready;
  logic                   err;

  modport master (
    input  win, win_valid, med_do, med_dso, res_ready,
    output win_ready, med_di, med_dsi, res, res_valid, err
  );

  modport slave (
    output win, win_valid, med_do, med_dso, res_ready,
    input  win_ready, med_di, med_dsi, res, res_valid, err
  );
endinterface

// File: rtl/median_shreg.sv
// Nine-entry parallel-load / serial-out pixel register; entry 0 is the head.
// Load and shift together drop pixel 0 on the load edge, leaving pixel 1 at the head.
module median_shreg
  import median_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   shift,
  input  logic [NB_PIX*SIZE-1:0] din,
  output logic [SIZE-1:0]        head
);
  logic [NB_PIX*SIZE-1:0] data;
  logic [NB_PIX*SIZE-1:0] src;

  always_comb begin
    src = data;
    if (load) src = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (load || shift) begin
      data <= shift ? (src >> SIZE) : src;
    end
  end

  assign head = data[SIZE-1:0];
endmodule

// File: rtl/median_feeder.sv
// Serialises a 3x3 window to the median core and returns the median via valid/ready.
// MEDIAN_FEEDER_TIMEOUT_EN adds a sticky ERR when the core stays silent for TIMEOUT cycles.
module median_feeder
  import median_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter int TIMEOUT = 63
) (
  input logic             clk,
  input logic             rst,
  median_feeder_if.master bus
);
  localparam int          CW       = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  LAST_IDX = 4'(NB_PIX - 1);

  state_t          state;
  logic [3:0]      idx;
  logic [CW-1:0]   wait_cnt;
  logic [CW-1:0]   wait_cnt_inc;
  logic [SIZE-1:0] di_q;
  logic [SIZE-1:0] res_q;
  logic            dsi_q;
  logic            res_valid_q;
  logic            hs;
  logic            shift;
  logic [SIZE-1:0] head;

  assign bus.win_ready = (state == IDLE) && !rst;
  assign hs            = bus.win_valid && bus.win_ready;
  assign shift         = hs || ((state == SEND) && (idx != LAST_IDX));
  assign wait_cnt_inc  = (wait_cnt == '1) ? wait_cnt : wait_cnt + CW'(1);

  median_shreg #(.SIZE(SIZE)) u_shreg (
    .clk  (clk),
    .rst  (rst),
    .load (hs),
    .shift(shift),
    .din  (bus.win),
    .head (head)
  );

`ifdef MEDIAN_FEEDER_TIMEOUT_EN
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
  logic err_q;
  logic timeout_hit;
  // Fires on the edge where the counter would reach TIMEOUT.
  assign timeout_hit = (wait_cnt_inc == TO_VAL);
  assign bus.err     = err_q;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      wait_cnt    <= '0;
      di_q        <= '0;
      dsi_q       <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            dsi_q <= 1'b1;
            di_q  <= bus.win[SIZE-1:0];
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (idx == LAST_IDX) begin
            dsi_q    <= 1'b0;
            di_q     <= '0;
            idx      <= '0;
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            idx  <= idx + 4'd1;
            di_q <= head;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt_inc;
          if (bus.med_dso) begin
            res_q       <= bus.med_do;
            res_valid_q <= 1'b1;
            state       <= HOLD;
          end
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
          else if (timeout_hit) begin
            err_q <= 1'b1;
            res_q <= '0;
            state <= IDLE;
          end
`endif
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.med_di    = di_q;
  assign bus.med_dsi   = dsi_q;
  assign bus.res       = res_q;
  assign bus.res_valid = res_valid_q;
endmodule

// File: tb/tb_median_feeder.sv
// Directed bench for median_feeder with a behavioural median core on the serial side.
module tb_median_feeder;
  import median_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  bit   stale;
  bit   silent;

  median_feeder_if #(.SIZE(8)) bus ();

  median_feeder #(.SIZE(8), .TIMEOUT(63)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural core: collects DSI pixels, answers MED_LATENCY cycles after DSI falls.
  logic [7:0] cap [9];
  int         ncap;
  int         lat;
  logic       busy;
  logic       mdso;
  logic [7:0] mdo;

  function automatic logic [7:0] median9(input logic [7:0] v [9]);
    logic [7:0] a [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) a[i] = v[i];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a[4];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ncap <= 0; lat <= 0; busy <= 1'b0; mdso <= 1'b0; mdo <= 8'd0;
    end else begin
      mdso <= 1'b0;
      if (bus.med_dsi) begin
        if (ncap < 9) cap[ncap] <= bus.med_di;
        ncap <= ncap + 1;
        busy <= 1'b1;
        lat  <= 0;
      end else if (busy) begin
        if (lat == MED_LATENCY - 1) begin
          mdso <= !silent;
          mdo  <= median9(cap);
          busy <= 1'b0;
          ncap <= 0;
        end else begin
          lat <= lat + 1;
        end
      end
    end
  end

  assign bus.med_do  = mdo;
  assign bus.med_dso = mdso | (stale & bus.med_dsi);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Entered on the negedge after WIN_VALID was raised; returns on the first RES_VALID negedge.
  task automatic send_check(input logic [71:0] w, input logic [7:0] exp_med, input bit hold_valid);
    int n;
    n = 0;
    while (!bus.med_dsi && n < 50) begin @(negedge clk); n++; end
    chk("dsi_start", 32'(bus.med_dsi), 1);
    if (!hold_valid) bus.win_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      chk("dsi_high", 32'(bus.med_dsi), 1);
      chk("di_seq", 32'(bus.med_di), 32'(w[k*8 +: 8]));
      chk("no_early_res", 32'(bus.res_valid), 0);
      @(negedge clk);
    end
    chk("dsi_fall", 32'(bus.med_dsi), 0);
    chk("di_idle", 32'(bus.med_di), 0);
    n = 0;
    while (!bus.res_valid && n < 200) begin @(negedge clk); n++; end
    chk("res_latency", n, 42);
    chk("res_value", 32'(bus.res), 32'(exp_med));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] w;
    int n;
    checks = 0; failures = 0; stale = 1'b0; silent = 1'b0;
    rst = 1'b1;
    bus.win = '0; bus.win_valid = 1'b0; bus.res_ready = 1'b0;

    #2;
    chk("rst_dsi", 32'(bus.med_dsi), 0);
    chk("rst_di", 32'(bus.med_di), 0);
    chk("rst_res", 32'(bus.res), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_win_ready", 32'(bus.win_ready), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_win_ready", 32'(bus.win_ready), 1);

    // Window {9,1,8,2,7,3,6,4,5}, then 10 cycles of backpressure.
    w = {8'd5, 8'd4, 8'd6, 8'd3, 8'd7, 8'd2, 8'd8, 8'd1, 8'd9};
    bus.win = w; bus.win_valid = 1'b1;
    @(negedge clk);
    send_check(w, 8'd5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_res", 32'(bus.res), 5);
      chk("bp_res_valid", 32'(bus.res_valid), 1);
      chk("bp_win_ready", 32'(bus.win_ready), 0);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    chk("xfer_win_ready", 32'(bus.win_ready), 0);
    @(negedge clk);
    chk("post_xfer_res_valid", 32'(bus.res_valid), 0);
    chk("post_xfer_win_ready", 32'(bus.win_ready), 1);
    chk("post_xfer_res_hold", 32'(bus.res), 5);

    // Back-to-back {0..8} then {255 x9}, with a stale DSO during SEND.
    stale = 1'b1;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(k);
    bus.win = w; bus.win_valid = 1'b1;
    @(negedge clk);
    send_check(w, 8'd4, 1'b1);
    w = {9{8'hFF}};
    bus.win = w;
    send_check(w, 8'd255, 1'b0);
    @(negedge clk);
    chk("b2b_single_valid", 32'(bus.res_valid), 0);
    stale = 1'b0;

    // Reset asserted during the 5th DSI cycle.
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(10 * (k + 1));
    bus.win = w; bus.win_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!bus.med_dsi && n < 50) begin @(negedge clk); n++; end
    bus.win_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_di_pix4", 32'(bus.med_di), 50);
    rst = 1'b1;
    #1;
    chk("mid_rst_dsi", 32'(bus.med_dsi), 0);
    chk("mid_rst_di", 32'(bus.med_di), 0);
    chk("mid_rst_res", 32'(bus.res), 0);
    chk("mid_rst_res_valid", 32'(bus.res_valid), 0);
    chk("mid_rst_win_ready", 32'(bus.win_ready), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("after_rst_win_ready", 32'(bus.win_ready), 1);
    chk("after_rst_dsi", 32'(bus.med_dsi), 0);
    bus.win_valid = 1'b1;
    @(negedge clk);
    send_check(w, 8'd50, 1'b0);
    @(negedge clk);

`ifdef MEDIAN_FEEDER_TIMEOUT_EN
    silent = 1'b1;
    bus.win_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!bus.med_dsi && n < 50) begin @(negedge clk); n++; end
    bus.win_valid = 1'b0;
    repeat (9) @(negedge clk);
    n = 0;
    while (!bus.err && n < 200) begin @(negedge clk); n++; end
    chk("to_cycles", n, 63);
    chk("to_err", 32'(bus.err), 1);
    chk("to_res_valid", 32'(bus.res_valid), 0);
    chk("to_res", 32'(bus.res), 0);
    chk("to_win_ready", 32'(bus.win_ready), 1);
    silent = 1'b0;
`else
    chk("err_tied_low", 32'(bus.err), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
